// File: rtl/display_pkg.sv
// Definitions shared by the blur processor and the display path: VGA 640x480@60 timing,
// source image geometry, frame-buffer address width and the packed RGB pixel type.
package display_pkg;
    localparam int SRC_W       = 160;
    localparam int SRC_H       = 120;
    localparam int SCALE_SHIFT = 2;
    localparam int ADDR_W      = 15;
    localparam int CNT_W       = 10;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

    typedef enum logic {
        WAIT_VBLANK = 1'b0,
        SWAP        = 1'b1
    } swap_state_t;
endpackage

// File: rtl/vga_timing_gen.sv
// Raster counters for the VGA output plus combinational sync/active decode and the
// vblank-start / frame-origin strobes, all in the counter (undelayed) domain.
module vga_timing_gen #(
    parameter int H_ACTIVE = display_pkg::H_ACTIVE,
    parameter int H_FP     = display_pkg::H_FP,
    parameter int H_SYNC   = display_pkg::H_SYNC,
    parameter int H_BP     = display_pkg::H_BP,
    parameter int V_ACTIVE = display_pkg::V_ACTIVE,
    parameter int V_FP     = display_pkg::V_FP,
    parameter int V_SYNC   = display_pkg::V_SYNC,
    parameter int V_BP     = display_pkg::V_BP
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          pixel_en,
    output logic [display_pkg::CNT_W-1:0] h,
    output logic [display_pkg::CNT_W-1:0] v,
    output logic                          active,
    output logic                          hsync_n,
    output logic                          vsync_n,
    output logic                          vblank_start,
    output logic                          frame_origin
);
    localparam int CW        = display_pkg::CNT_W;
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_LO = H_ACTIVE + H_FP;
    localparam int V_SYNC_LO = V_ACTIVE + V_FP;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h <= '0;
            v <= '0;
        end else if (pixel_en) begin
            if (h == CW'(H_TOTAL - 1)) begin
                h <= '0;
                v <= (v == CW'(V_TOTAL - 1)) ? '0 : v + CW'(1);
            end else begin
                h <= h + CW'(1);
            end
        end
    end

    assign active       = (h < CW'(H_ACTIVE)) && (v < CW'(V_ACTIVE));
    assign hsync_n      = !((h >= CW'(H_SYNC_LO)) && (h < CW'(H_SYNC_LO + H_SYNC)));
    assign vsync_n      = !((v >= CW'(V_SYNC_LO)) && (v < CW'(V_SYNC_LO + V_SYNC)));
    assign vblank_start = (h == '0) && (v == CW'(V_ACTIVE));
    assign frame_origin = (h == '0) && (v == '0);
endmodule

// File: rtl/frame_scan_out.sv
// Scan-out of the column-major source frame buffer, 4x upscaled onto the VGA raster, with
// the double-buffer swap taken only at the start of vertical blank so frames never tear.
module frame_scan_out
    import display_pkg::ADDR_W, display_pkg::CNT_W, display_pkg::pixel_t,
           display_pkg::swap_state_t, display_pkg::WAIT_VBLANK, display_pkg::SWAP;
#(
    parameter int SRC_H       = display_pkg::SRC_H,
    parameter int SCALE_SHIFT = display_pkg::SCALE_SHIFT,
    parameter int H_ACTIVE    = display_pkg::H_ACTIVE,
    parameter int H_FP        = display_pkg::H_FP,
    parameter int H_SYNC      = display_pkg::H_SYNC,
    parameter int H_BP        = display_pkg::H_BP,
    parameter int V_ACTIVE    = display_pkg::V_ACTIVE,
    parameter int V_FP        = display_pkg::V_FP,
    parameter int V_SYNC      = display_pkg::V_SYNC,
    parameter int V_BP        = display_pkg::V_BP
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pixel_en,
    input  logic [23:0]       frame_data,
    input  logic              swap_req,
    output logic [ADDR_W-1:0] display_address,
    output logic              buffer_sel,
    output logic              swap_ack,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              hsync,
    output logic              vsync,
    output logic              blank_n,
    output logic              frame_start
);
    logic [CNT_W-1:0]  h, v;
    logic              active0, hsync0_n, vsync0_n, vblank_start, frame_origin;
    logic              active1, hsync1_n, vsync1_n;
    logic [ADDR_W-1:0] addr_next;
    pixel_t            pix;
    swap_state_t       state, state_next;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .clk          (clk),
        .rst          (rst),
        .pixel_en     (pixel_en),
        .h            (h),
        .v            (v),
        .active       (active0),
        .hsync_n      (hsync0_n),
        .vsync_n      (vsync0_n),
        .vblank_start (vblank_start),
        .frame_origin (frame_origin)
    );

    // Column-major source: each group of 2^SCALE_SHIFT raster columns maps to one source column.
    assign addr_next = ADDR_W'(v >> SCALE_SHIFT) + ADDR_W'(h >> SCALE_SHIFT) * ADDR_W'(SRC_H);

    // Stage 1 issues the read and decodes timing; stage 2 lands the returned pixel with its syncs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            display_address <= '0;
            active1         <= 1'b0;
            hsync1_n        <= 1'b1;
            vsync1_n        <= 1'b1;
            pix             <= '0;
            hsync           <= 1'b1;
            vsync           <= 1'b1;
            blank_n         <= 1'b0;
        end else if (pixel_en) begin
            if (active0) begin
                display_address <= addr_next;
            end
            active1  <= active0;
            hsync1_n <= hsync0_n;
            vsync1_n <= vsync0_n;
            pix      <= active1 ? pixel_t'(frame_data) : '0;
            hsync    <= hsync1_n;
            vsync    <= vsync1_n;
            blank_n  <= active1;
        end
    end

    assign vga_r = pix.r;
    assign vga_g = pix.g;
    assign vga_b = pix.b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= WAIT_VBLANK;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            WAIT_VBLANK: if (pixel_en && vblank_start && swap_req) state_next = SWAP;
            SWAP:        state_next = WAIT_VBLANK;
            default:     state_next = WAIT_VBLANK;
        endcase
    end

    always_comb begin
        swap_ack = (state == SWAP);
    end

    // The toggle rides the same edge that enters SWAP, so it is aligned with swap_ack.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buffer_sel  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (state == WAIT_VBLANK && state_next == SWAP) begin
                buffer_sel <= ~buffer_sel;
            end
            frame_start <= pixel_en && frame_origin;
        end
    end
endmodule

// File: tb/tb_frame_scan_out.sv
// Self-checking bench for frame_scan_out on a shrunken raster, against a position-based model.
module tb_frame_scan_out;
    localparam int HA = 40, HFP = 4, HS = 8, HBP = 4, HT = HA + HFP + HS + HBP;
    localparam int VA = 32, VFP = 2, VS = 2, VBP = 3, VT = VA + VFP + VS + VBP;
    localparam int SH = 120, SS = 2;
    localparam int FRAME = HT * VT;
    localparam logic [44:0] RESET_VEC = {15'd0, 1'b0, 1'b0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b0};

    logic        clk = 1'b0, rst = 1'b0, pixel_en = 1'b0, swap_req = 1'b0;
    logic [23:0] frame_data;
    logic [14:0] display_address;
    logic        buffer_sel, swap_ack, hsync, vsync, blank_n, frame_start;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic [44:0] obs;

    int          n = 0, errors = 0, checks = 0;
    logic [14:0] m_addr = '0;
    logic        m_bsel = 1'b0, m_fs = 1'b0, m_ack = 1'b0;

    frame_scan_out #(
        .SRC_H(SH), .SCALE_SHIFT(SS),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk), .rst(rst), .pixel_en(pixel_en), .frame_data(frame_data),
        .swap_req(swap_req), .display_address(display_address), .buffer_sel(buffer_sel),
        .swap_ack(swap_ack), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Memory model: every word holds its own address, readable within the cycle.
    assign frame_data = {9'd0, display_address};
    assign obs = {display_address, buffer_sel, swap_ack, vga_r, vga_g, vga_b,
                  hsync, vsync, blank_n, frame_start};

    function automatic int pos_h(int k);
        return k % HT;
    endfunction

    function automatic int pos_v(int k);
        return (k / HT) % VT;
    endfunction

    function automatic logic is_active(int k);
        return (pos_h(k) < HA) && (pos_v(k) < VA);
    endfunction

    function automatic logic [14:0] addr_of(int k);
        return 15'((pos_v(k) >> SS) + (pos_h(k) >> SS) * SH);
    endfunction

    // Pins show the raster position two enabled steps back; the address shows the last visible one.
    function automatic logic [44:0] exp_vec();
        logic [23:0] rgb = '0;
        logic        hs = 1'b1, vs = 1'b1, bl = 1'b0;
        int          k;
        if (n >= 2) begin
            k  = n - 2;
            bl = is_active(k);
            rgb = bl ? {9'd0, addr_of(k)} : 24'd0;
            hs = !(pos_h(k) >= HA + HFP && pos_h(k) < HA + HFP + HS);
            vs = !(pos_v(k) >= VA + VFP && pos_v(k) < VA + VFP + VS);
        end
        return {m_addr, m_bsel, m_ack, rgb, hs, vs, bl, m_fs};
    endfunction

    task automatic model_reset();
        n = 0; m_addr = '0; m_bsel = 1'b0; m_fs = 1'b0; m_ack = 1'b0;
    endtask

    task automatic tick(input logic en);
        pixel_en = en;
        @(posedge clk);
        m_fs  = 1'b0;
        m_ack = 1'b0;
        if (en) begin
            if (is_active(n)) m_addr = addr_of(n);
            m_fs = (pos_h(n) == 0) && (pos_v(n) == 0);
            if (pos_h(n) == 0 && pos_v(n) == VA && swap_req) begin
                m_ack  = 1'b1;
                m_bsel = ~m_bsel;
            end
            n++;
        end
        #1;
    endtask

    function automatic int steps_to(int h, int v);
        return (v * HT + h - (n % FRAME) + FRAME) % FRAME;
    endfunction

    task automatic test_reset();
        pixel_en = 1'b1; swap_req = 1'b1;
        @(negedge clk); rst = 1'b0; #1;
        if (obs !== RESET_VEC) begin
            errors++; $display("FAIL reset_values got=%h want=%h", obs, RESET_VEC);
        end
        checks++;
        repeat (3) @(negedge clk);
        if (obs !== RESET_VEC) begin
            errors++; $display("FAIL reset_hold got=%h want=%h", obs, RESET_VEC);
        end
        checks++;
        pixel_en = 1'b0; swap_req = 1'b0;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_address_scan();
        int hs_low = 0, vs_low = 0, fs_cnt = 0;
        for (int i = 0; i < FRAME; i++) begin
            tick(1'b1);
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL scan step=%0d got=%h want=%h", n, obs, exp_vec());
            end
            checks++;
            if ((pos_h(n - 1) == 4 && pos_v(n - 1) == 0 && display_address !== 15'd120) ||
                (pos_h(n - 1) == 3 && pos_v(n - 1) == 7 && display_address !== 15'd1) ||
                (pos_h(n - 1) == HA - 1 && pos_v(n - 1) == VA - 1 && display_address !== 15'd1087)) begin
                errors++;
                $display("FAIL addr_point h=%0d v=%0d got=%0d", pos_h(n - 1), pos_v(n - 1), display_address);
            end
            if (is_active(n - 1)) checks++;
            hs_low += (hsync === 1'b0) ? 1 : 0;
            vs_low += (vsync === 1'b0) ? 1 : 0;
            fs_cnt += (frame_start === 1'b1) ? 1 : 0;
        end
        if (hs_low !== HS * VT) begin
            errors++; $display("FAIL hsync_low_count got=%0d want=%0d", hs_low, HS * VT);
        end
        checks++;
        if (vs_low !== VS * HT) begin
            errors++; $display("FAIL vsync_low_count got=%0d want=%0d", vs_low, VS * HT);
        end
        checks++;
        if (fs_cnt !== 1) begin
            errors++; $display("FAIL frame_start_count got=%0d want=1", fs_cnt);
        end
        checks++;
    endtask

    task automatic test_swap_mid_frame();
        int ack_cnt = 0, ack_pos = -1;
        for (int i = 0; i < FRAME; i++) begin
            if (pos_h(n) == 0 && pos_v(n) == 10) swap_req = 1'b1;
            tick(1'b1);
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL swap_mid step=%0d got=%h want=%h", n, obs, exp_vec());
            end
            checks++;
            if (swap_ack === 1'b1) begin
                ack_cnt++; ack_pos = n - 1; swap_req = 1'b0;
            end
        end
        if (ack_cnt !== 1 || pos_h(ack_pos) !== 0 || pos_v(ack_pos) !== VA || buffer_sel !== 1'b1) begin
            errors++;
            $display("FAIL swap_mid_timing acks=%0d at h=%0d v=%0d sel=%b want 1 ack at h=0 v=%0d sel=1",
                     ack_cnt, pos_h(ack_pos), pos_v(ack_pos), buffer_sel, VA);
        end
        checks++;
    endtask

    task automatic test_swap_same_cycle();
        int cnt = steps_to(0, VA);
        swap_req = 1'b0;
        for (int i = 0; i < cnt; i++) begin
            tick(1'b1);
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL swap_same_pre step=%0d got=%h want=%h", n, obs, exp_vec());
            end
            checks++;
        end
        swap_req = 1'b1;
        tick(1'b1);
        if (swap_ack !== 1'b1 || buffer_sel !== 1'b0) begin
            errors++; $display("FAIL swap_same_cycle ack=%b sel=%b want ack=1 sel=0", swap_ack, buffer_sel);
        end
        checks++;
        swap_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1);
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL swap_same_post step=%0d got=%h want=%h", n, obs, exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_no_swap();
        int changes = 0;
        logic sel0 = m_bsel;
        swap_req = 1'b0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick(1'b1);
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL no_swap step=%0d got=%h want=%h", n, obs, exp_vec());
            end
            checks++;
            changes += (buffer_sel !== sel0) ? 1 : 0;
        end
        if (changes !== 0) begin
            errors++; $display("FAIL no_swap_sel_changes got=%0d want=0", changes);
        end
        checks++;
    endtask

    task automatic test_sparse_enable();
        for (int i = 0; i < 4 * FRAME; i++) begin
            tick((i % 4) == 0);
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL sparse_en tick=%0d step=%0d got=%h want=%h", i, n, obs, exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4 * FRAME; i++) begin
            if ($urandom_range(0, 299) == 0) swap_req = ~swap_req;
            tick(1'($urandom_range(0, 1)));
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL random tick=%0d step=%0d got=%h want=%h", i, n, obs, exp_vec());
            end
            checks++;
        end
        swap_req = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int cnt = steps_to(0, VA);
        for (int i = 0; i < cnt; i++) tick(1'b1);
        swap_req = !m_bsel;
        tick(1'b1);
        swap_req = 1'b0;
        cnt = steps_to(30, 20);
        for (int i = 0; i < cnt; i++) begin
            tick(1'b1);
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL pre_reset step=%0d got=%h want=%h", n, obs, exp_vec());
            end
            checks++;
        end
        if (buffer_sel !== 1'b1) begin
            errors++; $display("FAIL pre_reset_sel got=%b want=1", buffer_sel);
        end
        checks++;
        #2 rst = 1'b0;
        #1;
        if (obs !== RESET_VEC) begin
            errors++; $display("FAIL reset_mid_frame got=%h want=%h", obs, RESET_VEC);
        end
        checks++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_reset();
        tick(1'b1);
        if (frame_start !== 1'b1 || buffer_sel !== 1'b0) begin
            errors++; $display("FAIL restart fs=%b sel=%b want fs=1 sel=0", frame_start, buffer_sel);
        end
        checks++;
        for (int i = 0; i < 2 * HT; i++) begin
            tick(1'b1);
            if (obs !== exp_vec()) begin
                errors++; $display("FAIL post_reset step=%0d got=%h want=%h", n, obs, exp_vec());
            end
            checks++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_address_scan();
        test_swap_mid_frame();
        test_swap_same_cycle();
        test_no_swap();
        test_sparse_enable();
        test_random();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
